// File: rtl/pkt_stream_gen.sv
// Packet stream generator: emits framed write beats and single-beat read requests
// to a NoC port, in interleaved (per frame) or batched (all writes first) order.
module pkt_stream_gen #(
  parameter int AVL_DATA_WIDTH  = 512,
  parameter int FRAME_ID_WIDTH  = 32,
  parameter int PORT_ID_WIDTH   = 4,
  parameter int PORT_ID         = 3,
  parameter int FRAME_BEATS     = 8,
  parameter int NUM_FRAMES      = 4,
  parameter int READS_PER_FRAME = 2,
  parameter int START_DELAY     = 3,
  parameter int WIDTH_PKT       = AVL_DATA_WIDTH + 2 + FRAME_ID_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic                 noc_ready_out,
  output logic [WIDTH_PKT-1:0] noc_data_in,
  output logic [3:0]           noc_valid_in,
  output logic [3:0]           noc_sop_in,
  output logic [3:0]           noc_eop_in,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           dbg_state
);

  // Handshake: a beat transfers on any rising edge where noc_valid_in is set and
  // noc_ready_out is high; while valid and not ready, every output holds its value.

  localparam int FIDX_W = FRAME_ID_WIDTH - PORT_ID_WIDTH;
  localparam int WNUM_W = (AVL_DATA_WIDTH < 32) ? AVL_DATA_WIDTH : 32;
  localparam int DLY_W  = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

  localparam logic [DLY_W-1:0]  LAST_DLY  = DLY_W'((START_DELAY == 0) ? 0 : START_DELAY - 1);
  localparam logic [7:0]        LAST_BEAT = 8'(FRAME_BEATS - 1);
  localparam logic [7:0]        LAST_RD   = 8'((READS_PER_FRAME == 0) ? 0 : READS_PER_FRAME - 1);
  localparam logic [FIDX_W-1:0] LAST_FIDX = FIDX_W'(NUM_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic [DLY_W-1:0]    dly_q, dly_d;
  logic [7:0]          beat_q, beat_d;
  logic [7:0]          rd_q, rd_d;
  logic [FIDX_W-1:0]   fidx_q, fidx_d;
  logic [WNUM_W-1:0]   wnum_q, wnum_d;
  logic [7:0]          rnum_q, rnum_d;
  logic                last_frame;
  logic [FIDX_W-1:0]   fid_rev;
  logic [FRAME_ID_WIDTH-1:0] frame_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      dly_q   <= '0;
      beat_q  <= '0;
      rd_q    <= '0;
      fidx_q  <= '0;
      wnum_q  <= '0;
      rnum_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dly_q   <= dly_d;
      beat_q  <= beat_d;
      rd_q    <= rd_d;
      fidx_q  <= fidx_d;
      wnum_q  <= wnum_d;
      rnum_q  <= rnum_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    dly_d      = dly_q;
    beat_d     = beat_q;
    rd_d       = rd_q;
    fidx_d     = fidx_q;
    wnum_d     = wnum_q;
    rnum_d     = rnum_q;
    last_frame = (fidx_q == LAST_FIDX);
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mode_d  = mode;
          dly_d   = '0;
          beat_d  = '0;
          rd_d    = '0;
          fidx_d  = '0;
          wnum_d  = WNUM_W'(1);
          rnum_d  = 8'd1;
          state_d = (START_DELAY == 0) ? S_WRITE : S_DELAY;
        end
      end
      S_DELAY: begin
        if (dly_q == LAST_DLY) state_d = S_WRITE;
        else                   dly_d   = dly_q + DLY_W'(1);
      end
      S_WRITE: begin
        if (noc_ready_out) begin
          wnum_d = wnum_q + WNUM_W'(1);
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            if (!mode_q) begin
              // Interleaved: this frame's reads follow its writes.
              if (READS_PER_FRAME != 0) state_d = S_READ;
              else if (last_frame)      state_d = S_DONE;
              else                      fidx_d  = fidx_q + FIDX_W'(1);
            end else if (!last_frame) begin
              fidx_d = fidx_q + FIDX_W'(1);
            end else if (READS_PER_FRAME != 0) begin
              // Batched: rewind to frame 0 for the read pass.
              state_d = S_READ;
              fidx_d  = '0;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      S_READ: begin
        if (noc_ready_out) begin
          rnum_d = rnum_q + 8'd1;
          if (rd_q == LAST_RD) begin
            rd_d = '0;
            if (last_frame) begin
              state_d = S_DONE;
            end else begin
              fidx_d = fidx_q + FIDX_W'(1);
              if (!mode_q) state_d = S_WRITE;
            end
          end else begin
            rd_d = rd_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fid_rev = '0;
    for (int i = 0; i < FIDX_W; i++) fid_rev[i] = fidx_q[FIDX_W-1-i];
    frame_id     = {PORT_ID_WIDTH'(PORT_ID), fid_rev};
    noc_valid_in = 4'h0;
    noc_sop_in   = 4'h0;
    noc_eop_in   = 4'h0;
    noc_data_in  = '0;
    if (state_q == S_WRITE) begin
      noc_valid_in = 4'hF;
      noc_sop_in   = {3'b000, beat_q == 8'd0};
      noc_eop_in   = {beat_q == LAST_BEAT, 3'b000};
      noc_data_in  = {1'b1, 1'b0, frame_id, AVL_DATA_WIDTH'(wnum_q)};
    end else if (state_q == S_READ) begin
      noc_valid_in = 4'hF;
      noc_sop_in   = 4'h1;
      noc_eop_in   = 4'h8;
      noc_data_in  = {1'b0, 1'b1, frame_id, rnum_q, {(AVL_DATA_WIDTH-8){1'b0}}};
    end
  end

  assign busy      = (state_q == S_DELAY) || (state_q == S_WRITE) || (state_q == S_READ);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pkt_stream_gen.sv
// Directed bench for pkt_stream_gen: default instance for both ordering modes,
// backpressure, reset abort and restart; a second instance for single-beat frames.
module tb_pkt_stream_gen;

  localparam int AW = 512;
  localparam int FW = 32;
  localparam int WP = AW + 2 + FW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, start1, mode, ready;
  logic [WP-1:0] data, data1;
  logic [3:0]    valid, sop, eop, valid1, sop1, eop1;
  logic          busy, done, busy1, done1;
  logic [2:0]    dbg, dbg1;

  int vectors = 0;
  int miscompares = 0;

  logic [WP+1:0] exp_q[$];
  logic [WP-1:0] got[$];

  always #5 clk = ~clk;

  pkt_stream_gen dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .noc_ready_out(ready),
    .noc_data_in(data), .noc_valid_in(valid), .noc_sop_in(sop), .noc_eop_in(eop),
    .busy(busy), .done(done), .dbg_state(dbg)
  );

  pkt_stream_gen #(.FRAME_BEATS(1), .READS_PER_FRAME(0), .NUM_FRAMES(2), .START_DELAY(0)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(1'b0), .noc_ready_out(ready),
    .noc_data_in(data1), .noc_valid_in(valid1), .noc_sop_in(sop1), .noc_eop_in(eop1),
    .busy(busy1), .done(done1), .dbg_state(dbg1)
  );

  task automatic check(input string tag, input logic [WP-1:0] obs, input logic [WP-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WP-1:0] mk_pkt(input bit w, input int f, input logic [AW-1:0] d);
    logic [27:0] r;
    for (int i = 0; i < 28; i++) r[i] = f[27-i];
    return {w, ~w, 4'h3, r, d};
  endfunction

  // Expected beat list for the default instance: {sop, eop, packet}.
  task automatic build_exp(input logic m);
    int wn, rn;
    logic [AW-1:0] rd;
    exp_q.delete();
    wn = 1;
    rn = 1;
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 8; k++) begin
        exp_q.push_back({k == 0, k == 7, mk_pkt(1'b1, f, AW'(wn))});
        wn++;
      end
      if (!m) begin
        for (int r = 0; r < 2; r++) begin
          rd = '0;
          rd[AW-1 -: 8] = 8'(rn);
          exp_q.push_back({2'b11, mk_pkt(1'b0, f, rd)});
          rn++;
        end
      end
    end
    if (m) begin
      for (int f = 0; f < 4; f++) begin
        for (int r = 0; r < 2; r++) begin
          rd = '0;
          rd[AW-1 -: 8] = 8'(rn);
          exp_q.push_back({2'b11, mk_pkt(1'b0, f, rd)});
          rn++;
        end
      end
    end
  endtask

  task automatic run_dut(input logic m, input bit rnd, input int poke_at);
    int cyc, idle, beats;
    bit stall, last_fire, ended;
    logic [WP-1:0] p_data;
    logic [3:0] p_sop, p_eop;
    logic [WP+1:0] e;
    build_exp(m);
    got.delete();
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode  = ~m;
    cyc = 0; idle = 0; beats = 0; stall = 0; last_fire = 0; ended = 0;
    p_data = '0; p_sop = '0; p_eop = '0;
    while (!ended && cyc < 600) begin
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (cyc == poke_at);
      if (busy && done) check("busy_and_done", WP'(1), WP'(0));
      if (valid == 4'hF) begin
        if (stall) begin
          check("hold_data", data, p_data);
          check("hold_sop", WP'(sop), WP'(p_sop));
          check("hold_eop", WP'(eop), WP'(p_eop));
        end
        if (ready) begin
          if (exp_q.size() == 0) begin
            check("extra_beat", WP'(1), WP'(0));
          end else begin
            e = exp_q.pop_front();
            check("beat_data", data, e[WP-1:0]);
            check("beat_sop", WP'(sop), WP'({3'b000, e[WP+1]}));
            check("beat_eop", WP'(eop), WP'({e[WP], 3'b000}));
          end
          got.push_back(data);
          beats++;
        end
        stall = !ready;
        last_fire = ready;
        p_data = data; p_sop = sop; p_eop = eop;
      end else begin
        if (done) begin
          check("done_after_last_beat", WP'(last_fire), WP'(1));
          ended = 1;
        end else if (busy) begin
          idle++;
        end
        stall = 0;
        last_fire = 0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("run_finished", WP'(ended), WP'(1));
    check("idle_cycles", WP'(idle), WP'(3));
    check("beat_count", WP'(beats), WP'(40));
    check("beats_missing", WP'(exp_q.size()), WP'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, WP'(valid), WP'(0));
    check({tag, "_sop"}, WP'(sop), WP'(0));
    check({tag, "_eop"}, WP'(eop), WP'(0));
    check({tag, "_data"}, data, '0);
    check({tag, "_busy"}, WP'(busy), WP'(0));
    check({tag, "_done"}, WP'(done), WP'(0));
    check({tag, "_state"}, WP'(dbg), WP'(0));
  endtask

  initial begin
    int n, cyc;
    logic [WP-1:0] ev;
    rst = 1'b0; start = 1'b0; start1 = 1'b0; mode = 1'b0; ready = 1'b1;
    #2;
    check_reset_outputs("reset");
    check("reset_valid1", WP'(valid1), WP'(0));
    @(negedge clk);
    rst = 1'b1;

    // Interleaved, ready always high.
    run_dut(1'b0, 1'b0, -1);
    check("m0_count", WP'(got.size()), WP'(40));
    if (got.size() == 40) begin
      ev = {2'b10, 32'h3000_0000, AW'(1)};
      check("m0_first_beat", got[0], ev);
      ev = {2'b10, 32'h3000_0000, AW'(8)};
      check("m0_beat8", got[7], ev);
      ev = {2'b01, 32'h3000_0000, 8'd2, {(AW-8){1'b0}}};
      check("m0_read2", got[9], ev);
      ev = {2'b10, 32'h3800_0000, AW'(9)};
      check("m0_frame1_first", got[10], ev);
      ev = {2'b10, 32'h3800_0000, AW'(16)};
      check("m0_frame1_last", got[17], ev);
    end

    // Batched.
    run_dut(1'b1, 1'b0, -1);
    if (got.size() == 40) begin
      ev = {2'b10, 32'h3C00_0000, AW'(32)};
      check("m1_last_write", got[31], ev);
      ev = {2'b01, 32'h3000_0000, 8'd1, {(AW-8){1'b0}}};
      check("m1_read1", got[32], ev);
      ev = {2'b01, 32'h3800_0000, 8'd3, {(AW-8){1'b0}}};
      check("m1_read3", got[34], ev);
      ev = {2'b01, 32'h3C00_0000, 8'd8, {(AW-8){1'b0}}};
      check("m1_read8", got[39], ev);
    end

    // Backpressure with random ready.
    run_dut(1'b0, 1'b1, -1);

    // Start pulse while busy (and mode flipped) is ignored; also a start from DONE.
    run_dut(1'b0, 1'b0, 12);

    // Reset after the 5th accepted beat.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; cyc = 0;
    while (n < 5 && cyc < 100) begin
      if (valid == 4'hF) n++;
      if (n < 5) @(negedge clk);
      cyc++;
    end
    check("abort_reached_beat5", WP'(n), WP'(5));
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst = 1'b1;
    run_dut(1'b0, 1'b0, -1);

    // Single-beat frames, no reads, two frames, no start delay.
    @(negedge clk);
    ready = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("sb_valid0", WP'(valid1), WP'(4'hF));
    check("sb_sop0", WP'(sop1), WP'(4'h1));
    check("sb_eop0", WP'(eop1), WP'(4'h8));
    ev = {2'b10, 32'h3000_0000, AW'(1)};
    check("sb_data0", data1, ev);
    @(negedge clk);
    check("sb_valid1", WP'(valid1), WP'(4'hF));
    check("sb_sop1", WP'(sop1), WP'(4'h1));
    check("sb_eop1", WP'(eop1), WP'(4'h8));
    ev = {2'b10, 32'h3800_0000, AW'(2)};
    check("sb_data1", data1, ev);
    @(negedge clk);
    check("sb_end_valid", WP'(valid1), WP'(0));
    check("sb_end_done", WP'(done1), WP'(1));
    check("sb_end_busy", WP'(busy1), WP'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
